// File: rtl/pred_pht_ctrl.sv
// Arbitrates a single-port synchronous 2-bit-counter PHT between fetch predictions,
// queued execute-stage training (read-modify-write) and a post-reset init sweep.
module pred_pht_ctrl #(
  parameter int         INDEX_BITS = 7,
  parameter int         TQ_DEPTH   = 4,
  parameter logic [1:0] INIT_VAL   = 2'b01
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pred_req_i,
  input  logic [INDEX_BITS-1:0] pred_idx_i,
  output logic                  pred_gnt_o,
  output logic                  pred_valid_o,
  output logic                  pred_taken_o,
  input  logic                  train_req_i,
  input  logic [INDEX_BITS-1:0] train_idx_i,
  input  logic                  train_taken_i,
  output logic                  train_rdy_o,
  output logic                  pht_en_o,
  output logic                  pht_we_o,
  output logic [INDEX_BITS-1:0] pht_addr_o,
  output logic [1:0]            pht_wdata_o,
  input  logic [1:0]            pht_rdata_i,
  output logic                  init_busy_o
);

  localparam int PTR_W = (TQ_DEPTH > 1) ? $clog2(TQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(TQ_DEPTH + 1);

  typedef enum logic [1:0] {INIT, IDLE, TUPD} state_t;

  state_t                state, next_state;
  logic [INDEX_BITS-1:0] sweep;
  logic [INDEX_BITS-1:0] tq_idx   [TQ_DEPTH];
  logic                  tq_taken [TQ_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full, empty, push, pop;
  logic                  pred_valid_q;
  logic [INDEX_BITS-1:0] head_idx;
  logic                  head_taken;
  logic [1:0]            upd_val;

  assign full       = (count == CNT_W'(TQ_DEPTH));
  assign empty      = (count == '0);
  assign head_idx   = tq_idx[rd_ptr];
  assign head_taken = tq_taken[rd_ptr];

  // Gated by rst_i so reset forces these combinational outputs immediately.
  assign train_rdy_o  = !rst_i && (state != INIT) && !full;
  assign init_busy_o  = rst_i || (state == INIT);
  assign push         = train_req_i && train_rdy_o;
  assign pred_valid_o = pred_valid_q;
  assign pred_taken_o = pred_valid_q & pht_rdata_i[1];

  always_comb begin
    if (head_taken) upd_val = (pht_rdata_i == 2'b11) ? 2'b11 : pht_rdata_i + 2'd1;
    else            upd_val = (pht_rdata_i == 2'b00) ? 2'b00 : pht_rdata_i - 2'd1;
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    next_state  = state;
    pht_en_o    = 1'b0;
    pht_we_o    = 1'b0;
    pht_addr_o  = '0;
    pht_wdata_o = '0;
    pred_gnt_o  = 1'b0;
    pop         = 1'b0;
    if (!rst_i) begin
      case (state)
        INIT: begin
          pht_en_o    = 1'b1;
          pht_we_o    = 1'b1;
          pht_addr_o  = sweep;
          pht_wdata_o = INIT_VAL;
          if (sweep == {INDEX_BITS{1'b1}}) next_state = IDLE;
        end
        IDLE: begin
          // A full queue outranks prediction so training can never starve.
          if (full || (!pred_req_i && !empty)) begin
            pht_en_o   = 1'b1;
            pht_addr_o = head_idx;
            next_state = TUPD;
          end else if (pred_req_i) begin
            pred_gnt_o = 1'b1;
            pht_en_o   = 1'b1;
            pht_addr_o = pred_idx_i;
          end
        end
        TUPD: begin
          pht_en_o    = 1'b1;
          pht_we_o    = 1'b1;
          pht_addr_o  = head_idx;
          pht_wdata_o = upd_val;
          pop         = 1'b1;
          next_state  = IDLE;
        end
        default: next_state = INIT;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= INIT;
      sweep        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      pred_valid_q <= 1'b0;
    end else begin
      state        <= next_state;
      pred_valid_q <= pred_gnt_o;
      if (state == INIT) sweep <= sweep + 1'b1;
      if (push) wr_ptr <= (wr_ptr == PTR_W'(TQ_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(TQ_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: queue storage has no reset; only the pointers and count define valid entries.
  always_ff @(posedge clk_i) begin
    if (push) begin
      tq_idx[wr_ptr]   <= train_idx_i;
      tq_taken[wr_ptr] <= train_taken_i;
    end
  end

endmodule
